// File: rtl/dcnn_chain_row_core_if.sv
// Config, weight, pixel and result signals of the row-convolution core.
// The master side drives jobs into the core; the slave side is the core itself.
interface dcnn_chain_row_core_if #(
  parameter int unsigned DW      = 16,
  parameter int unsigned K_BITS  = 4,
  parameter int unsigned RL_BITS = 8,
  parameter int unsigned CH_BITS = 8
);
  logic               start;
  logic [K_BITS-1:0]  cfg_k_size;
  logic               cfg_stride2;
  logic [RL_BITS-1:0] cfg_row_len;
  logic [CH_BITS-1:0] cfg_num_ch;
  logic [4:0]         cfg_shift;
  logic               cfg_relu;
  logic               w_vld;
  logic [DW-1:0]      w_data;
  logic               in_vld;
  logic               in_rdy;
  logic [DW-1:0]      in_data;
  logic               out_vld;
  logic               out_rdy;
  logic [DW-1:0]      out_data;
  logic               out_last;
  logic               busy;
  logic               done;
  logic               cfg_err;

  modport master (
    output start, cfg_k_size, cfg_stride2, cfg_row_len, cfg_num_ch, cfg_shift, cfg_relu,
    output w_vld, w_data, in_vld, in_data, out_rdy,
    input  in_rdy, out_vld, out_data, out_last, busy, done, cfg_err
  );

  modport slave (
    input  start, cfg_k_size, cfg_stride2, cfg_row_len, cfg_num_ch, cfg_shift, cfg_relu,
    input  w_vld, w_data, in_vld, in_data, out_rdy,
    output in_rdy, out_vld, out_data, out_last, busy, done, cfg_err
  );
endinterface

// File: rtl/dcnn_chain_row_core.sv
// K-tap weight-stationary 1D row convolution; partial sums accumulate across input channels in
// a row buffer, and the final channel streams shifted, saturated, optionally ReLU'd results.
module dcnn_chain_row_core #(
  parameter int unsigned DW      = 16,
  parameter int unsigned ACCW    = 40,
  parameter int unsigned PARA    = 9,
  parameter int unsigned K_BITS  = 4,
  parameter int unsigned RL_BITS = 8,
  parameter int unsigned CH_BITS = 8
) (
  input logic                  clk,
  input logic                  rst,
  dcnn_chain_row_core_if.slave bus_io
);
  localparam int unsigned Depth = 2 ** RL_BITS;
  localparam int unsigned PW    = 2 * DW;

  typedef enum logic [2:0] {StIdle, StLoadW, StRun, StChDrain, StDrain} state_e;
  state_e state_q, state_d;

  logic [K_BITS-1:0]  k_q;
  logic               s2_q;
  logic [RL_BITS-1:0] len_q;
  logic [CH_BITS-1:0] nch_q;
  logic [4:0]         shift_q;
  logic               relu_q;
  logic [RL_BITS-1:0] last_idx_q;

  // Weights stored reversed (wr_q[a] = w[k-1-a]) so tap a pairs with the pixel of age a.
  logic signed [DW-1:0] wr_q   [PARA];
  logic signed [DW-1:0] win_q  [PARA];
  logic signed [DW-1:0] win_sh [PARA];
  logic [K_BITS-1:0]    wcnt_q;
  logic [RL_BITS-1:0]   n_q;
  logic [RL_BITS-1:0]   j_q;
  logic [CH_BITS-1:0]   ch_q;

  logic                 p1_vld_q;
  logic                 p1_last_q;
  logic [RL_BITS-1:0]   p1_idx_q;
  logic signed [PW-1:0] prod_q [PARA];
  logic signed [PW-1:0] prod_d [PARA];

  logic signed [ACCW-1:0] row_buf [Depth];
  logic signed [ACCW-1:0] sum;
  logic signed [ACCW-1:0] acc_new;
  logic signed [ACCW-1:0] shifted;
  logic signed [DW-1:0]   res;

  logic          out_vld_q;
  logic          out_last_q;
  logic [DW-1:0] out_data_q;
  logic          done_q;
  logic          err_q;

  logic               stall;
  logic               in_rdy;
  logic               accept;
  logic               fire;
  logic               row_end;
  logic               last_w;
  logic               is_final;
  logic               cfg_ok;
  logic               start_ok;
  logic [RL_BITS:0]   n_nxt;
  logic [K_BITS-1:0]  widx;
  logic [RL_BITS-1:0] span;

  assign stall    = out_vld_q & ~bus_io.out_rdy;
  assign accept   = bus_io.in_vld & in_rdy;
  assign n_nxt    = {1'b0, n_q} + (RL_BITS + 1)'(1);
  // Result fires once the window is full and (n - k) is a multiple of the stride.
  assign fire     = accept && (32'(n_nxt) >= 32'(k_q)) && (!s2_q || (n_nxt[0] == k_q[0]));
  assign row_end  = accept && (n_nxt == {1'b0, len_q});
  assign last_w   = (wcnt_q == k_q - K_BITS'(1));
  assign widx     = k_q - K_BITS'(1) - wcnt_q;
  assign is_final = (({1'b0, ch_q} + (CH_BITS + 1)'(1)) == {1'b0, nch_q});
  assign start_ok = (state_q == StIdle) && bus_io.start;
  assign span     = bus_io.cfg_row_len - RL_BITS'(bus_io.cfg_k_size);
  assign cfg_ok   = (bus_io.cfg_k_size != '0) && (32'(bus_io.cfg_k_size) <= PARA) &&
                    (32'(bus_io.cfg_row_len) >= 32'(bus_io.cfg_k_size)) &&
                    (bus_io.cfg_num_ch != '0);

  always_comb begin
    win_sh[0] = bus_io.in_data;
    for (int a = 1; a < PARA; a++) win_sh[a] = win_q[a-1];
    for (int a = 0; a < PARA; a++) begin
      prod_d[a] = (a < int'(k_q)) ? PW'(wr_q[a]) * PW'(win_sh[a]) : '0;
    end
  end

  always_comb begin
    sum = '0;
    for (int a = 0; a < PARA; a++) sum = sum + ACCW'(prod_q[a]);
    acc_new = (ch_q == '0) ? sum : row_buf[p1_idx_q] + sum;
    shifted = acc_new >>> shift_q;
    if ((&shifted[ACCW-1:DW-1]) || (~|shifted[ACCW-1:DW-1])) begin
      res = shifted[DW-1:0];
    end else if (shifted[ACCW-1]) begin
      res = {1'b1, {(DW - 1){1'b0}}};
    end else begin
      res = {1'b0, {(DW - 1){1'b1}}};
    end
    if (relu_q && res[DW-1]) res = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start_ok && cfg_ok) state_d = StLoadW;
      StLoadW:   if (bus_io.w_vld && last_w) state_d = StRun;
      StRun:     if (row_end) state_d = is_final ? StDrain : StChDrain;
      StChDrain: if (!p1_vld_q) state_d = StLoadW;
      StDrain: begin
        if (!p1_vld_q && out_vld_q && bus_io.out_rdy && out_last_q) state_d = StIdle;
      end
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    in_rdy          = (state_q == StRun) && !stall;
    bus_io.in_rdy   = in_rdy;
    bus_io.busy     = (state_q != StIdle);
    bus_io.out_vld  = out_vld_q;
    bus_io.out_data = out_data_q;
    bus_io.out_last = out_last_q;
    bus_io.done     = done_q;
    bus_io.cfg_err  = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q        <= '0;
      s2_q       <= 1'b0;
      len_q      <= '0;
      nch_q      <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      last_idx_q <= '0;
      wcnt_q     <= '0;
      n_q        <= '0;
      j_q        <= '0;
      ch_q       <= '0;
      p1_vld_q   <= 1'b0;
      p1_last_q  <= 1'b0;
      p1_idx_q   <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int a = 0; a < PARA; a++) begin
        wr_q[a]   <= '0;
        win_q[a]  <= '0;
        prod_q[a] <= '0;
      end
    end else begin
      done_q <= (state_q == StDrain) && (state_d == StIdle);
      err_q  <= start_ok && !cfg_ok;

      if (start_ok && cfg_ok) begin
        k_q        <= bus_io.cfg_k_size;
        s2_q       <= bus_io.cfg_stride2;
        len_q      <= bus_io.cfg_row_len;
        nch_q      <= bus_io.cfg_num_ch;
        shift_q    <= bus_io.cfg_shift;
        relu_q     <= bus_io.cfg_relu;
        last_idx_q <= bus_io.cfg_stride2 ? (span >> 1) : span;
        wcnt_q     <= '0;
        ch_q       <= '0;
      end

      if ((state_q == StLoadW) && bus_io.w_vld) begin
        for (int a = 0; a < PARA; a++) begin
          if (K_BITS'(a) == widx) wr_q[a] <= bus_io.w_data;
        end
        wcnt_q <= last_w ? '0 : wcnt_q + K_BITS'(1);
        // New row: restart pixel/output counters and flush the window.
        if (last_w) begin
          n_q <= '0;
          j_q <= '0;
          for (int a = 0; a < PARA; a++) win_q[a] <= '0;
        end
      end

      if (accept) begin
        for (int a = 0; a < PARA; a++) win_q[a] <= win_sh[a];
        n_q <= n_nxt[RL_BITS-1:0];
      end
      if (fire) j_q <= j_q + RL_BITS'(1);

      if ((state_q == StChDrain) && (state_d == StLoadW)) ch_q <= ch_q + CH_BITS'(1);

      if (!stall) begin
        p1_vld_q <= fire;
        if (fire) begin
          for (int a = 0; a < PARA; a++) prod_q[a] <= prod_d[a];
          p1_idx_q  <= j_q;
          p1_last_q <= (j_q == last_idx_q);
        end
        out_vld_q  <= p1_vld_q && is_final;
        out_last_q <= p1_vld_q && is_final && p1_last_q;
        if (p1_vld_q && is_final) out_data_q <= res;
      end
    end
  end

  // Row buffer holds no reset: channel 0 always overwrites before any read.
  always_ff @(posedge clk) begin
    if (!rst && !stall && p1_vld_q) row_buf[p1_idx_q] <= acc_new;
  end

endmodule

// File: tb/tb_dcnn_chain_row_core.sv
// Directed bench for dcnn_chain_row_core: hand-computed rows, stride 2, multi-channel
// accumulation, saturation/ReLU, backpressure, config error and mid-job reset.
module tb_dcnn_chain_row_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcnn_chain_row_core_if #(.DW(16), .K_BITS(4), .RL_BITS(8), .CH_BITS(8)) bus ();

  dcnn_chain_row_core #(
    .DW(16), .ACCW(40), .PARA(9), .K_BITS(4), .RL_BITS(8), .CH_BITS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_io(bus)
  );

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int got[$];
  bit got_last[$];
  int acc_cyc[$];
  int first_vld_cyc = -1;
  int last_hs_cyc = -1;
  int done_cyc = -1;
  int hold_bad;
  int rdy_bad;
  int wq[$];
  int xq[$];
  int eq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (bus.out_vld && bus.out_rdy) begin
      got.push_back(int'($signed(bus.out_data)));
      got_last.push_back(bus.out_last);
      if (bus.out_last) last_hs_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic clear_log();
    got.delete();
    got_last.delete();
    acc_cyc.delete();
    first_vld_cyc = -1;
    last_hs_cyc = -1;
  endtask

  task automatic start_job(input int k, input int s2, input int len, input int ch,
                           input int sh, input int relu);
    bus.cfg_k_size  = 4'(k);
    bus.cfg_stride2 = 1'(s2);
    bus.cfg_row_len = 8'(len);
    bus.cfg_num_ch  = 8'(ch);
    bus.cfg_shift   = 5'(sh);
    bus.cfg_relu    = 1'(relu);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic load_w(input int w[$]);
    for (int i = 0; i < w.size(); i++) begin
      bus.w_vld  = 1'b1;
      bus.w_data = 16'(w[i]);
      @(posedge clk); #1;
    end
    bus.w_vld = 1'b0;
  endtask

  task automatic send_px(input int x[$], input int n);
    for (int i = 0; i < n; i++) begin
      int waited = 0;
      bit ok = 1'b0;
      bus.in_vld  = 1'b1;
      bus.in_data = 16'(x[i]);
      while (!ok && waited < 100) begin
        @(negedge clk);
        if (bus.in_rdy) begin
          ok = 1'b1;
          acc_cyc.push_back(cyc);
        end
        @(posedge clk); #1;
        waited++;
      end
      if (!ok) check_eq("px_accept_timeout", 0, 1);
    end
    bus.in_vld = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    done_cyc = -1;
    while (n < 200 && done_cyc < 0) begin
      @(negedge clk);
      n++;
      if (bus.done) done_cyc = cyc;
    end
    check_eq({tag, "_done_seen"}, int'(done_cyc >= 0), 1);
    @(posedge clk); #1;
  endtask

  task automatic check_row(input string tag, input int e[$]);
    check_eq({tag, "_count"}, got.size(), e.size());
    for (int i = 0; i < e.size(); i++) begin
      if (i < got.size()) begin
        check_eq($sformatf("%s_y%0d", tag, i), got[i], e[i]);
        check_eq($sformatf("%s_last%0d", tag, i), int'(got_last[i]), int'(i == e.size() - 1));
      end
    end
  endtask

  task automatic run_row(input int k, input int s2, input int len, input int sh,
                         input int relu, input int w[$], input int x[$]);
    clear_log();
    start_job(k, s2, len, 1, sh, relu);
    load_w(w);
    send_px(x, len);
  endtask

  task automatic stall_watch();
    int w = 0;
    hold_bad = 0;
    rdy_bad = 0;
    @(negedge clk);
    while (!bus.out_vld && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_eq("t5_vld_seen", int'(bus.out_vld), 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.in_rdy) rdy_bad++;
      if (int'($signed(bus.out_data)) != 14 || !bus.out_vld) hold_bad++;
    end
    check_eq("t5_in_rdy_low", rdy_bad, 0);
    check_eq("t5_data_held", hold_bad, 0);
    check_eq("t5_no_hs_while_stalled", got.size(), 0);
    @(posedge clk); #1;
    bus.out_rdy = 1'b1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.cfg_k_size = '0;
    bus.cfg_stride2 = 1'b0;
    bus.cfg_row_len = '0;
    bus.cfg_num_ch = '0;
    bus.cfg_shift = '0;
    bus.cfg_relu = 1'b0;
    bus.w_vld = 1'b0;
    bus.w_data = '0;
    bus.in_vld = 1'b0;
    bus.in_data = '0;
    bus.out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check_eq("rst_flags", int'({bus.in_rdy, bus.out_vld, bus.out_last, bus.busy, bus.done,
                                bus.cfg_err}), 0);
    check_eq("rst_data", int'(bus.out_data), 0);
    @(posedge clk); #1;

    // 1: k=3 s=1 L=5, weights 1,2,3
    wq = {1, 2, 3};
    xq = {1, 2, 3, 4, 5};
    run_row(3, 0, 5, 0, 0, wq, xq);
    wait_done("t1");
    eq = {14, 20, 26};
    check_row("t1", eq);
    check_eq("t1_done_lat", done_cyc - last_hs_cyc, 1);
    @(negedge clk);
    check_eq("t1_done_one_cycle", int'(bus.done), 0);
    check_eq("t1_busy_after", int'(bus.busy), 0);
    @(posedge clk); #1;

    // 2: stride 2
    wq = {1, 1, 1};
    xq = {1, 2, 3, 4, 5, 6, 7};
    run_row(3, 1, 7, 0, 0, wq, xq);
    wait_done("t2");
    eq = {6, 12, 18};
    check_row("t2", eq);
    check_eq("t2_first_vld_lat", first_vld_cyc - ((acc_cyc.size() > 2) ? acc_cyc[2] : 0), 2);

    // 3: two channels accumulate
    clear_log();
    start_job(3, 0, 5, 2, 0, 0);
    wq = {1, 1, 1};
    xq = {1, 2, 3, 4, 5};
    load_w(wq);
    send_px(xq, 5);
    repeat (5) @(posedge clk);
    #1;
    check_eq("t3_no_out_ch0", got.size(), 0);
    check_eq("t3_no_vld_ch0", first_vld_cyc, -1);
    wq = {2, 0, 0};
    xq = {10, 11, 12, 13, 14};
    load_w(wq);
    send_px(xq, 5);
    wait_done("t3");
    eq = {26, 31, 36};
    check_row("t3", eq);

    // 4: saturation and ReLU with k=1, shift 4
    wq = {1000};
    xq = {1000};
    run_row(1, 0, 1, 4, 0, wq, xq);
    wait_done("t4a");
    eq = {32767};
    check_row("t4a", eq);
    xq = {-1000};
    run_row(1, 0, 1, 4, 0, wq, xq);
    wait_done("t4b");
    eq = {-32768};
    check_row("t4b", eq);
    run_row(1, 0, 1, 4, 1, wq, xq);
    wait_done("t4c");
    eq = {0};
    check_row("t4c", eq);

    // 5: backpressure at first result
    clear_log();
    bus.out_rdy = 1'b0;
    start_job(3, 0, 5, 1, 0, 0);
    wq = {1, 2, 3};
    xq = {1, 2, 3, 4, 5};
    load_w(wq);
    fork
      send_px(xq, 5);
      stall_watch();
    join
    wait_done("t5");
    eq = {14, 20, 26};
    check_row("t5", eq);

    // 6: illegal config, then reset mid-run, then a clean rerun
    clear_log();
    start_job(0, 0, 5, 1, 0, 0);
    @(negedge clk);
    check_eq("t6_cfg_err_pulse", int'(bus.cfg_err), 1);
    check_eq("t6_busy_on_err", int'(bus.busy), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("t6_cfg_err_drop", int'(bus.cfg_err), 0);
    check_eq("t6_busy_stays_0", int'(bus.busy), 0);
    @(posedge clk); #1;

    start_job(3, 0, 5, 2, 0, 0);
    wq = {1, 1, 1};
    xq = {1, 2, 3, 4, 5};
    load_w(wq);
    send_px(xq, 4);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("t6_rst_flags", int'({bus.in_rdy, bus.out_vld, bus.out_last, bus.busy, bus.done,
                                   bus.cfg_err}), 0);
    check_eq("t6_rst_data", int'(bus.out_data), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("t6_no_residual", got.size(), 0);

    wq = {1, 2, 3};
    xq = {1, 2, 3, 4, 5};
    run_row(3, 0, 5, 0, 0, wq, xq);
    wait_done("t6");
    eq = {14, 20, 26};
    check_row("t6", eq);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
